// File: rtl/id_issue_pkg.sv
// Shared types and encodings for the decode/issue stage.
// ALU op/sel codes are the ones the EX-stage ALU consumes.
package id_issue_pkg;

  typedef logic [7:0] aluop_t;
  typedef logic [2:0] alusel_t;

  localparam aluop_t EXE_NOP_OP  = 8'b0000_0000;
  localparam aluop_t EXE_AND_OP  = 8'b0010_0100;
  localparam aluop_t EXE_OR_OP   = 8'b0010_0101;
  localparam aluop_t EXE_XOR_OP  = 8'b0010_0110;
  localparam aluop_t EXE_NOR_OP  = 8'b0010_0111;
  localparam aluop_t EXE_ANDI_OP = 8'b0101_1001;
  localparam aluop_t EXE_ORI_OP  = 8'b0101_1010;
  localparam aluop_t EXE_XORI_OP = 8'b0101_1011;
  localparam aluop_t EXE_LUI_OP  = 8'b0101_1100;
  localparam aluop_t EXE_SLL_OP  = 8'b0111_1100;
  localparam aluop_t EXE_SLLV_OP = 8'b0000_0100;
  localparam aluop_t EXE_SRL_OP  = 8'b0000_0010;
  localparam aluop_t EXE_SRLV_OP = 8'b0000_0110;
  localparam aluop_t EXE_SRA_OP  = 8'b0000_0011;
  localparam aluop_t EXE_SRAV_OP = 8'b0000_0111;

  localparam alusel_t EXE_RES_NOP   = 3'b000;
  localparam alusel_t EXE_RES_LOGIC = 3'b001;
  localparam alusel_t EXE_RES_SHIFT = 3'b010;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;

  typedef enum logic [1:0] {
    S1_RS, S1_SA, S1_ZERO
  } src1_e;

  typedef enum logic [1:0] {
    S2_RT, S2_IMM, S2_IMM_HI, S2_ZERO
  } src2_e;

  typedef struct packed {
    aluop_t     aluop;
    alusel_t    alusel;
    src1_e      src1;
    src2_e      src2;
    logic [4:0] waddr;
    logic       wreg;
    logic       illegal;
  } dec_t;

  typedef struct packed {
    logic        valid;
    aluop_t      aluop;
    alusel_t     alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic        wreg;
    logic [4:0]  waddr;
    logic        illegal;
  } issue_t;

  localparam issue_t ISSUE_NOP = '{
    valid:   1'b0,
    aluop:   EXE_NOP_OP,
    alusel:  EXE_RES_NOP,
    reg1:    32'h0,
    reg2:    32'h0,
    wreg:    1'b0,
    waddr:   5'd0,
    illegal: 1'b0
  };

  // Youngest producer wins; $0 always reads as zero.
  function automatic logic [31:0] fwd(
    input logic [4:0]  a,
    input logic [31:0] rf,
    input logic        ew,
    input logic [4:0]  ea,
    input logic [31:0] ed,
    input logic        mw,
    input logic [4:0]  ma,
    input logic [31:0] md,
    input logic        ww,
    input logic [4:0]  wa,
    input logic [31:0] wd
  );
    if (a == 5'd0)            return 32'h0;
    else if (ew && ea == a)   return ed;
    else if (mw && ma == a)   return md;
    else if (ww && wa == a)   return wd;
    else                      return rf;
  endfunction

endpackage

// File: rtl/id_issue_if.sv
// Issue bus from the ID/EX register into the EX-stage ALU.
// master = decode/issue stage, slave = EX stage.
interface id_issue_if;
  import id_issue_pkg::*;

  logic        valid_o;
  aluop_t      aluop_o;
  alusel_t     alusel_o;
  logic [31:0] reg1_o;
  logic [31:0] reg2_o;
  logic        wreg_o;
  logic [4:0]  waddr_o;
  logic        illegal_o;

  modport master (
    output valid_o, aluop_o, alusel_o,
    output reg1_o, reg2_o,
    output wreg_o, waddr_o, illegal_o
  );

  modport slave (
    input valid_o, aluop_o, alusel_o,
    input reg1_o, reg2_o,
    input wreg_o, waddr_o, illegal_o
  );
endinterface

// File: rtl/id_issue_decode.sv
// Combinational decode of MIPS logic/shift instructions
// into ALU op/sel, operand selects and destination.
module id_decode
  import id_issue_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [4:0] rt_i,
  input  logic [4:0] rd_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '{
      aluop:   EXE_NOP_OP,
      alusel:  EXE_RES_NOP,
      src1:    S1_ZERO,
      src2:    S2_ZERO,
      waddr:   5'd0,
      wreg:    1'b0,
      illegal: 1'b1
    };
    unique case (1'b1)
      (op_i == OP_SPECIAL): begin
        dec_o.illegal = 1'b0;
        dec_o.waddr   = rd_i;
        dec_o.src1    = S1_RS;
        dec_o.src2    = S2_RT;
        dec_o.alusel  = EXE_RES_LOGIC;
        unique case (funct_i)
          F_AND:  dec_o.aluop = EXE_AND_OP;
          F_OR:   dec_o.aluop = EXE_OR_OP;
          F_XOR:  dec_o.aluop = EXE_XOR_OP;
          F_NOR:  dec_o.aluop = EXE_NOR_OP;
          F_SLL, F_SRL, F_SRA: begin
            dec_o.alusel = EXE_RES_SHIFT;
            dec_o.src1   = S1_SA;
            dec_o.aluop  = (funct_i == F_SLL) ? EXE_SLL_OP :
                           (funct_i == F_SRL) ? EXE_SRL_OP :
                                                EXE_SRA_OP;
          end
          F_SLLV, F_SRLV, F_SRAV: begin
            dec_o.alusel = EXE_RES_SHIFT;
            dec_o.aluop  = (funct_i == F_SLLV) ? EXE_SLLV_OP :
                           (funct_i == F_SRLV) ? EXE_SRLV_OP :
                                                 EXE_SRAV_OP;
          end
          default: begin
            dec_o.illegal = 1'b1;
            dec_o.waddr   = 5'd0;
            dec_o.src1    = S1_ZERO;
            dec_o.src2    = S2_ZERO;
            dec_o.alusel  = EXE_RES_NOP;
          end
        endcase
      end
      (op_i == OP_ANDI),
      (op_i == OP_ORI),
      (op_i == OP_XORI): begin
        dec_o.illegal = 1'b0;
        dec_o.waddr   = rt_i;
        dec_o.src1    = S1_RS;
        dec_o.src2    = S2_IMM;
        dec_o.alusel  = EXE_RES_LOGIC;
        dec_o.aluop   = (op_i == OP_ANDI) ? EXE_ANDI_OP :
                        (op_i == OP_ORI)  ? EXE_ORI_OP  :
                                            EXE_XORI_OP;
      end
      (op_i == OP_LUI): begin
        dec_o.illegal = 1'b0;
        dec_o.waddr   = rt_i;
        dec_o.src2    = S2_IMM_HI;
        dec_o.alusel  = EXE_RES_LOGIC;
        dec_o.aluop   = EXE_LUI_OP;
      end
      default: ;
    endcase
    // Writes to $0 are dropped so 0x00000000 issues harmlessly.
    dec_o.wreg = !dec_o.illegal && (dec_o.waddr != 5'd0);
  end

endmodule

// File: rtl/id_issue.sv
// Decode/issue stage: regfile read, EX/MEM/WB forwarding
// and the ID/EX issue register with stall/flush.
module id_issue
  import id_issue_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_i,
  output logic        inst_ready_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [4:0]  rf_raddr1_o,
  output logic [4:0]  rf_raddr2_o,
  input  logic [31:0] rf_rdata1_i,
  input  logic [31:0] rf_rdata2_i,
  input  logic        ex_wreg_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        mem_wreg_i,
  input  logic [4:0]  mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        wb_wreg_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  id_issue_if.master  iss
);

  dec_t        dec;
  issue_t      issue_d, issue_q;
  logic [31:0] rs_val, rt_val;
  logic [31:0] op1, op2;

  id_decode u_dec (
    .op_i    (inst_i[31:26]),
    .rt_i    (inst_i[20:16]),
    .rd_i    (inst_i[15:11]),
    .funct_i (inst_i[5:0]),
    .dec_o   (dec)
  );

  assign inst_ready_o = !stall_i;
  assign rf_raddr1_o  = inst_i[25:21];
  assign rf_raddr2_o  = inst_i[20:16];

  always_comb begin
    rs_val = fwd(inst_i[25:21], rf_rdata1_i,
                 ex_wreg_i, ex_waddr_i, ex_wdata_i,
                 mem_wreg_i, mem_waddr_i, mem_wdata_i,
                 wb_wreg_i, wb_waddr_i, wb_wdata_i);
    rt_val = fwd(inst_i[20:16], rf_rdata2_i,
                 ex_wreg_i, ex_waddr_i, ex_wdata_i,
                 mem_wreg_i, mem_waddr_i, mem_wdata_i,
                 wb_wreg_i, wb_waddr_i, wb_wdata_i);
  end

  always_comb begin
    op1 = 32'h0;
    op2 = 32'h0;
    case (dec.src1)
      S1_RS:   op1 = rs_val;
      S1_SA:   op1 = {27'b0, inst_i[10:6]};
      default: op1 = 32'h0;
    endcase
    case (dec.src2)
      S2_RT:     op2 = rt_val;
      S2_IMM:    op2 = {16'b0, inst_i[15:0]};
      S2_IMM_HI: op2 = {inst_i[15:0], 16'b0};
      default:   op2 = 32'h0;
    endcase
  end

  always_comb begin
    issue_d = issue_q;
    if (flush_i) begin
      issue_d = ISSUE_NOP;
    end else if (stall_i) begin
      issue_d = issue_q;
    end else if (inst_valid_i) begin
      issue_d = '{
        valid:   1'b1,
        aluop:   dec.aluop,
        alusel:  dec.alusel,
        reg1:    op1,
        reg2:    op2,
        wreg:    dec.wreg,
        waddr:   dec.waddr,
        illegal: dec.illegal
      };
    end else begin
      issue_d = ISSUE_NOP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) issue_q <= ISSUE_NOP;
    else       issue_q <= issue_d;
  end

  assign iss.valid_o   = issue_q.valid;
  assign iss.aluop_o   = issue_q.aluop;
  assign iss.alusel_o  = issue_q.alusel;
  assign iss.reg1_o    = issue_q.reg1;
  assign iss.reg2_o    = issue_q.reg2;
  assign iss.wreg_o    = issue_q.wreg;
  assign iss.waddr_o   = issue_q.waddr;
  assign iss.illegal_o = issue_q.illegal;

endmodule

// File: tb/tb_id_issue.sv
// Self-checking bench for id_issue: directed vectors, a
// behavioural issue model checked every cycle, literal pins.
module tb_id_issue;
  import id_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ivalid = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        ready;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1 = 32'h0, rd2 = 32'h0;
  logic        ew = 1'b0, mw = 1'b0, ww = 1'b0;
  logic [4:0]  ea = 5'd0, ma = 5'd0, wa = 5'd0;
  logic [31:0] ed = 32'h0, md = 32'h0, wd = 32'h0;

  int checks = 0;
  int failures = 0;

  id_issue_if iss ();

  id_issue dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .inst_valid_i (ivalid),
    .inst_i       (inst),
    .inst_ready_o (ready),
    .stall_i      (stall),
    .flush_i      (flush),
    .rf_raddr1_o  (ra1),
    .rf_raddr2_o  (ra2),
    .rf_rdata1_i  (rd1),
    .rf_rdata2_i  (rd2),
    .ex_wreg_i    (ew),
    .ex_waddr_i   (ea),
    .ex_wdata_i   (ed),
    .mem_wreg_i   (mw),
    .mem_waddr_i  (ma),
    .mem_wdata_i  (md),
    .wb_wreg_i    (ww),
    .wb_waddr_i   (wa),
    .wb_wdata_i   (wd),
    .iss          (iss)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        wreg;
    logic [4:0]  wa;
    logic        ill;
  } exp_t;

  localparam exp_t BUBBLE = '{1'b0, 8'h00, 3'b000,
                              32'h0, 32'h0, 1'b0, 5'd0, 1'b0};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Value a source register must read: $0, then youngest stage, then rf.
  function automatic logic [31:0] src(input logic [4:0] a,
                                      input logic [31:0] rf);
    logic        w [3];
    logic [4:0]  ad [3];
    logic [31:0] dv [3];
    w  = '{ew, mw, ww};
    ad = '{ea, ma, wa};
    dv = '{ed, md, wd};
    if (a == 5'd0) return 32'h0;
    for (int i = 0; i < 3; i++)
      if (w[i] && ad[i] == a) return dv[i];
    return rf;
  endfunction

  function automatic exp_t mdl(input logic [31:0] x);
    exp_t e;
    logic [5:0]  op, fn;
    logic [31:0] rs, rt, sa, imm;
    op  = x[31:26];
    fn  = x[5:0];
    rs  = src(x[25:21], rd1);
    rt  = src(x[20:16], rd2);
    sa  = 32'(x[10:6]);
    imm = 32'(x[15:0]);
    e = BUBBLE;
    e.valid = 1'b1;
    e.ill = 1'b0;
    if (op == 6'd0 && fn inside {F_AND, F_OR, F_XOR, F_NOR}) begin
      e.alusel = EXE_RES_LOGIC; e.r1 = rs; e.r2 = rt;
      e.wa = x[15:11];
      e.aluop = fn == F_AND ? EXE_AND_OP : fn == F_OR ? EXE_OR_OP :
                fn == F_XOR ? EXE_XOR_OP : EXE_NOR_OP;
    end else if (op == 6'd0 && fn inside {F_SLL, F_SRL, F_SRA}) begin
      e.alusel = EXE_RES_SHIFT; e.r1 = sa; e.r2 = rt;
      e.wa = x[15:11];
      e.aluop = fn == F_SLL ? EXE_SLL_OP :
                fn == F_SRL ? EXE_SRL_OP : EXE_SRA_OP;
    end else if (op == 6'd0 &&
                 fn inside {F_SLLV, F_SRLV, F_SRAV}) begin
      e.alusel = EXE_RES_SHIFT; e.r1 = rs; e.r2 = rt;
      e.wa = x[15:11];
      e.aluop = fn == F_SLLV ? EXE_SLLV_OP :
                fn == F_SRLV ? EXE_SRLV_OP : EXE_SRAV_OP;
    end else if (op inside {OP_ANDI, OP_ORI, OP_XORI}) begin
      e.alusel = EXE_RES_LOGIC; e.r1 = rs; e.r2 = imm;
      e.wa = x[20:16];
      e.aluop = op == OP_ANDI ? EXE_ANDI_OP :
                op == OP_ORI ? EXE_ORI_OP : EXE_XORI_OP;
    end else if (op == OP_LUI) begin
      e.alusel = EXE_RES_LOGIC; e.r1 = 32'h0;
      e.r2 = imm << 16; e.wa = x[20:16];
      e.aluop = EXE_LUI_OP;
    end else begin
      e.ill = 1'b1;
    end
    e.wreg = !e.ill && e.wa != 5'd0;
    return e;
  endfunction

  exp_t m = BUBBLE;

  always @(posedge clk) begin
    if (rst || flush)   m <= BUBBLE;
    else if (stall)     m <= m;
    else if (ivalid)    m <= mdl(inst);
    else                m <= BUBBLE;
  end

  always @(posedge clk) begin
    #1;
    chk("m.valid",  32'(iss.valid_o),   32'(m.valid));
    chk("m.aluop",  32'(iss.aluop_o),   32'(m.aluop));
    chk("m.alusel", 32'(iss.alusel_o),  32'(m.alusel));
    chk("m.reg1",   iss.reg1_o,         m.r1);
    chk("m.reg2",   iss.reg2_o,         m.r2);
    chk("m.wreg",   32'(iss.wreg_o),    32'(m.wreg));
    chk("m.waddr",  32'(iss.waddr_o),   32'(m.wa));
    chk("m.ill",    32'(iss.illegal_o), 32'(m.ill));
    chk("m.ready",  32'(ready),         32'(!stall));
    chk("m.raddr1", 32'(ra1),           32'(inst[25:21]));
    chk("m.raddr2", 32'(ra2),           32'(inst[20:16]));
  end

  task automatic drv(input logic v, input logic [31:0] x,
                     input logic st, input logic fl);
    ivalid = v; inst = x; stall = st; flush = fl;
    @(negedge clk);
  endtask

  task automatic nofwd();
    ew = 1'b0; mw = 1'b0; ww = 1'b0;
    ea = 5'd0; ma = 5'd0; wa = 5'd0;
    ed = 32'h0; md = 32'h0; wd = 32'h0;
  endtask

  logic [31:0] sweep [8] = '{
    32'h00853804, 32'h00853806, 32'h00853807, 32'h00053840,
    32'h00053882, 32'h00853826, 32'h38A7F0F0, 32'h00000000
  };

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst.valid", 32'(iss.valid_o), 32'h0);
    chk("rst.aluop", 32'(iss.aluop_o), 32'(EXE_NOP_OP));
    chk("rst.reg1",  iss.reg1_o, 32'h0);
    rst = 1'b0;

    rd1 = 32'h0000DEAD; rd2 = 32'h0000BEEF;
    drv(1, 32'h34011100, 0, 0);
    chk("ori.reg1",  iss.reg1_o, 32'h0);
    chk("ori.reg2",  iss.reg2_o, 32'h00001100);
    chk("ori.waddr", 32'(iss.waddr_o), 32'd1);
    chk("ori.op",    32'(iss.aluop_o), 32'(EXE_ORI_OP));
    chk("ori.wreg",  32'(iss.wreg_o), 32'd1);

    ew = 1; ea = 5'd1; ed = 32'h1100;
    rd1 = 32'hBAD0BAD0; rd2 = 32'hBAD0BAD0;
    drv(1, 32'h00211025, 0, 0);
    chk("or.reg1",  iss.reg1_o, 32'h00001100);
    chk("or.reg2",  iss.reg2_o, 32'h00001100);
    chk("or.waddr", 32'(iss.waddr_o), 32'd2);

    nofwd();
    drv(1, 32'h3C03ABCD, 0, 0);
    chk("lui.reg2", iss.reg2_o, 32'hABCD0000);
    mw = 1; ma = 5'd3; md = 32'hABCD0000;
    drv(1, 32'h00032103, 0, 0);
    chk("sra.reg1", iss.reg1_o, 32'd4);
    chk("sra.reg2", iss.reg2_o, 32'hABCD0000);
    chk("sra.op",   32'(iss.aluop_o), 32'(EXE_SRA_OP));
    chk("sra.sel",  32'(iss.alusel_o), 32'(EXE_RES_SHIFT));

    ew = 1; ea = 5'd5; ed = 32'h1;
    mw = 1; ma = 5'd5; md = 32'h2;
    ww = 1; wa = 5'd5; wd = 32'h3;
    drv(1, 32'h00A53025, 0, 0);
    chk("pri.ex", iss.reg1_o, 32'h1);
    ew = 0;
    drv(1, 32'h00A53025, 0, 0);
    chk("pri.mem", iss.reg1_o, 32'h2);
    ew = 1; ea = 5'd0; ma = 5'd0; wa = 5'd0;
    drv(1, 32'h00003025, 0, 0);
    chk("pri.zero", iss.reg1_o, 32'h0);

    nofwd();
    rd1 = 32'h12345678;
    drv(1, 32'h30A700FF, 0, 0);
    chk("andi.reg1", iss.reg1_o, 32'h12345678);
    rd1 = 32'hFFFF0000;
    for (int i = 0; i < 3; i++) begin
      drv(1, 32'h38A7F0F0, 1, 0);
      chk("stall.reg1", iss.reg1_o, 32'h12345678);
      chk("stall.op", 32'(iss.aluop_o), 32'(EXE_ANDI_OP));
      chk("stall.ready", 32'(ready), 32'h0);
    end
    drv(1, 32'h38A7F0F0, 1, 1);
    chk("flush.valid", 32'(iss.valid_o), 32'h0);
    drv(1, 32'h38A7F0F0, 0, 0);
    chk("xori.reg1", iss.reg1_o, 32'hFFFF0000);
    drv(0, 32'h38A7F0F0, 0, 0);
    chk("idle.valid", 32'(iss.valid_o), 32'h0);

    drv(1, 32'hFC000000, 0, 0);
    chk("ill.valid", 32'(iss.valid_o), 32'h1);
    chk("ill.ill",   32'(iss.illegal_o), 32'h1);
    chk("ill.wreg",  32'(iss.wreg_o), 32'h0);
    chk("ill.op",    32'(iss.aluop_o), 32'(EXE_NOP_OP));
    drv(1, 32'h00224027, 0, 0);
    chk("nor.ill", 32'(iss.illegal_o), 32'h0);
    chk("nor.op",  32'(iss.aluop_o), 32'(EXE_NOR_OP));

    rd1 = 32'h0F0F0F0F; rd2 = 32'h00000009;
    ww = 1; wa = 5'd5; wd = 32'h00000003;
    foreach (sweep[i]) drv(1, sweep[i], 0, 0);
    chk("zero.wreg",  32'(iss.wreg_o), 32'h0);
    chk("zero.valid", 32'(iss.valid_o), 32'h1);
    nofwd();

    drv(1, 32'h34011100, 0, 0);
    chk("pre.valid", 32'(iss.valid_o), 32'h1);
    rst = 1'b1;
    drv(1, 32'h34011100, 1, 0);
    chk("rst2.valid", 32'(iss.valid_o), 32'h0);
    chk("rst2.reg2",  iss.reg2_o, 32'h0);
    chk("rst2.ready", 32'(ready), 32'h0);
    stall = 1'b0;
    #1;
    chk("rst2.ready1", 32'(ready), 32'h1);
    rst = 1'b0;
    drv(0, 32'h0, 0, 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
